// File: rtl/reg_file_mp.sv
// Multi-port register file with a busy scoreboard and a power-up/clear sweep.
// Registers are zeroed one per cycle by the INIT sweep and have no reset, so the array can map to distributed RAM.

module reg_file_mp_rd #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_EN = 1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_busy,
  input  logic              wa_we,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  logic is_zero;
  assign is_zero = (ZERO_EN != 0) && (addr == '0);

  // wa_we/wb_we already exclude address 0, so the bypass cannot leak a write to r0
  always_comb begin
    data = st_data;
    busy = st_busy;
    if (BYPASS != 0) begin
      if (wa_we && wa_addr == addr) data = wa_data;
      if (wb_we && wb_addr == addr) data = wb_data;
    end
    if (!run || is_zero) begin
      data = '0;
      busy = 1'b0;
    end
  end
endmodule

module reg_file_mp #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int N_RD    = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_EN = 1
) (
  input  logic                     clock,
  input  logic                     n_rst,
  input  logic                     clr,
  input  logic [N_RD*ADDR_W-1:0]   r_addr,
  output logic [N_RD*DATA_W-1:0]   r_data,
  output logic [N_RD-1:0]          r_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     ready
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              run, sweep;
  logic              wa_we, wb_we, rsv_we;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0] regs [NREG];

  logic [N_RD-1:0][ADDR_W-1:0] ra;
  logic [N_RD-1:0][DATA_W-1:0] rd;

  assign ra     = r_addr;
  assign r_data = rd;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (clr) state_d = S_INIT;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    run   = (state_q == S_RUN);
    sweep = (state_q == S_INIT);
    ready = run;
  end

  // Effective enables: gated by RUN and, with ZERO_EN, blind to address 0
  assign wa_we  = run && wa_en  && !((ZERO_EN != 0) && (wa_addr  == '0));
  assign wb_we  = run && wb_en  && !((ZERO_EN != 0) && (wb_addr  == '0));
  assign rsv_we = run && rsv_en && !((ZERO_EN != 0) && (rsv_addr == '0));

  // Port B is written last so it wins a same-address collision
  always_ff @(posedge clock) begin
    if (sweep) begin
      regs[cnt_q] <= '0;
    end else begin
      if (wa_we) regs[wa_addr] <= wa_data;
      if (wb_we) regs[wb_addr] <= wb_data;
    end
  end

  // Reservation applied after write clears: set wins
  always_comb begin
    busy_d = busy_q;
    if (sweep) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      if (wa_we)  busy_d[wa_addr]  = 1'b0;
      if (wb_we)  busy_d[wb_addr]  = 1'b0;
      if (rsv_we) busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    reg_file_mp_rd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .ZERO_EN(ZERO_EN)
    ) u_rd (
      .run    (run),
      .addr   (ra[k]),
      .st_data(regs[ra[k]]),
      .st_busy(busy_q[ra[k]]),
      .wa_we  (wa_we),
      .wa_addr(wa_addr),
      .wa_data(wa_data),
      .wb_we  (wb_we),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .data   (rd[k]),
      .busy   (r_busy[k])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: array-level reference model checked every cycle, plus directed literal checks.
module tb_reg_file_mp;
  localparam int DW = 16, AW = 3, NR = 2, NREG = 8;

  logic            clock = 1'b0;
  logic            n_rst = 1'b0;
  logic            clr = 1'b0;
  logic [NR*AW-1:0] r_addr = '0;
  logic [NR*DW-1:0] r_data;
  logic [NR-1:0]   r_busy;
  logic            wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0]   wa_addr = '0, wb_addr = '0, rsv_addr = '0;
  logic [DW-1:0]   wa_data = '0, wb_data = '0;
  logic            ready;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  reg_file_mp dut (
    .clock(clock), .n_rst(n_rst), .clr(clr),
    .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
  );

  always #5 clock = ~clock;

  // Reference: contents, busy flags and the number of sweep cycles still to run
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;
  int              m_left;

  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      m_left = NREG;
      m_busy = '0;
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (clr) begin
      m_left = NREG;
      m_busy = '0;
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    end else begin
      if (wa_en && wa_addr != 0) begin m_mem[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
      if (wb_en && wb_addr != 0) begin m_mem[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (m_left > 0 || a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (m_left > 0 || a == 0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return r_data[k*DW +: DW];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    r_addr[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_ready", {31'd0, ready}, {31'd0, m_left == 0});
      for (int k = 0; k < NR; k++) begin
        chk("model_rdata", {16'd0, r_data[k*DW +: DW]}, {16'd0, exp_data(r_addr[k*AW +: AW])});
        chk("model_rbusy", {31'd0, r_busy[k]}, {31'd0, exp_busy(r_addr[k*AW +: AW])});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    chk_en = 1'b1;
    #1 n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("init_ready", ready, 0);
      chk("init_rd", rd(0), 0);
    end
    @(negedge clock); chk("run_ready", ready, 1);

    tick(); wa_en = 1; wa_addr = 3; wa_data = 16'h1234; set_ra(0, 3); set_ra(1, 3);
    @(negedge clock); chk("byp_r3", rd(0), 16'h1234);
    tick(); wa_en = 0;
    @(negedge clock); chk("hold_r3", rd(1), 16'h1234);

    tick(); wa_en = 1; wa_addr = 5; wa_data = 16'hAAAA; wb_en = 1; wb_addr = 5; wb_data = 16'h5555; set_ra(0, 5);
    @(negedge clock); chk("byp_b_wins", rd(0), 16'h5555);
    tick(); wb_en = 0; wa_addr = 0; wa_data = 16'hFFFF; set_ra(0, 0); set_ra(1, 5);
    @(negedge clock); chk("r0_byp", rd(0), 0); chk("r5_b_wins", rd(1), 16'h5555);
    tick(); wa_en = 0;
    @(negedge clock); chk("r0_zero", rd(0), 0);

    tick(); rsv_en = 1; rsv_addr = 2; set_ra(0, 2);
    @(negedge clock); chk("busy_pre", r_busy[0], 0);
    tick(); rsv_en = 0;
    @(negedge clock); chk("busy_set", r_busy[0], 1);
    tick(); wa_en = 1; wa_addr = 2; wa_data = 16'h0022;
    @(negedge clock); chk("busy_nobyp", r_busy[0], 1); chk("r2_byp", rd(0), 16'h0022);
    tick(); wa_en = 0;
    @(negedge clock); chk("busy_clr", r_busy[0], 0);
    tick(); rsv_en = 1; wb_en = 1; wb_addr = 2; wb_data = 16'h0033;
    tick(); rsv_en = 0; wb_en = 0;
    @(negedge clock); chk("busy_setwins", r_busy[0], 1); chk("r2_wb", rd(0), 16'h0033);
    tick(); rsv_en = 1; rsv_addr = 0; set_ra(1, 0);
    tick(); rsv_en = 0;
    @(negedge clock); chk("r0_busy", r_busy[1], 0);

    for (int i = 1; i < 8; i++) begin
      tick(); wa_en = 1; wa_addr = AW'(i); wa_data = DW'(16'h1000 + i);
    end
    tick(); wa_en = 0; set_ra(0, 7);
    @(negedge clock); chk("r7_loaded", rd(0), 16'h1007);

    // clr sweep with writes/reservations and a stray clr pulse during it
    tick(); clr = 1;
    tick(); clr = 0; wa_en = 1; wa_addr = 4; wa_data = 16'hBEEF; rsv_en = 1; rsv_addr = 4;
    set_ra(0, 4); set_ra(1, 4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("clr_ready", ready, 0);
      chk("clr_rd", rd(0), 0);
      if (i == 3) clr = 1;
      if (i == 5) clr = 0;
    end
    tick(); wa_en = 0; rsv_en = 0;
    @(negedge clock); chk("clr_done", ready, 1); chk("r4_dropped", rd(0), 0); chk("r4_busy", r_busy[0], 0);
    for (int i = 1; i < 8; i++) begin
      tick(); set_ra(0, AW'(i));
      @(negedge clock); chk("swept", rd(0), 0);
    end

    // reset at sweep cycle 4
    tick(); clr = 1;
    tick(); clr = 0;
    repeat (4) @(posedge clock);
    #1 n_rst = 0;
    #1 chk("rst_sweep_ready", ready, 0);
    @(posedge clock); #1 n_rst = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); chk("rst_sweep_wait", ready, 0);
    end
    @(negedge clock); chk("rst_sweep_done", ready, 1);

    // reset mid-RUN
    tick(); wa_en = 1; wa_addr = 6; wa_data = 16'h6666; set_ra(0, 6); rsv_en = 1; rsv_addr = 1; set_ra(1, 1);
    tick(); wa_en = 0; rsv_en = 0;
    @(negedge clock); chk("r6_loaded", rd(0), 16'h6666); chk("r1_rsv", r_busy[1], 1);
    #1 n_rst = 0;
    #1 chk("rst_run_ready", ready, 0); chk("rst_run_busy", r_busy[1], 0);
    @(posedge clock); #1 n_rst = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); chk("rst_run_wait", ready, 0);
    end
    @(negedge clock); chk("rst_run_done", ready, 1); chk("r6_cleared", rd(0), 0); chk("r1_busy_cleared", r_busy[1], 0);

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
